// File: rtl/window_buffer_nxn_controller_if.sv
// Handshake and status bundle between the upstream line buffers and the NxN window controller.
interface window_buffer_nxn_controller_if #(
  parameter int unsigned CW = 10,
  parameter int unsigned RW = 9
);
  logic          done_i;
  logic          valid_i;
  logic          abort_i;
  logic          ready_o;
  logic          count_en;
  logic          done_o;
  logic          progress_done;
  logic [CW-1:0] col_o;
  logic [RW-1:0] row_o;
  logic          busy_o;

  // Upstream / test side: drives requests, observes controller status.
  modport master (
    output done_i, valid_i, abort_i,
    input  ready_o, count_en, done_o, progress_done, col_o, row_o, busy_o
  );

  // Controller side.
  modport slave (
    input  done_i, valid_i, abort_i,
    output ready_o, count_en, done_o, progress_done, col_o, row_o, busy_o
  );
endinterface

// File: rtl/window_buffer_nxn_controller.sv
// Frame sequencer for a KxK sliding-window buffer: primes K-1 columns per line,
// flags each valid window column, inserts inter-line gaps and pulses at frame end.
module window_buffer_nxn_controller #(
  parameter int unsigned K       = 7,
  parameter int unsigned IMG_W   = 640,
  parameter int unsigned IMG_H   = 480,
  parameter int unsigned GAP_CYC = 2
) (
  input logic clk,
  input logic rst_n,
  window_buffer_nxn_controller_if.slave bus
);

  localparam int unsigned CW       = $clog2(IMG_W);
  localparam int unsigned RW       = $clog2(IMG_H);
  localparam int unsigned OUT_ROWS = IMG_H - K + 1;
  localparam int unsigned GW       = $clog2(GAP_CYC + 1);

  localparam logic [CW-1:0] COL_PRIME = CW'(K - 2);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(OUT_ROWS - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_FILL   = 3'd2,
    S_OUT    = 3'd3,
    S_GAP    = 3'd4,
    S_FINISH = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          prog_q, prog_d;
  logic          accept;
  logic          in_out;

  // Next-state, counter updates and status decode of the upcoming state.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    gap_d   = gap_q;
    accept  = 1'b0;
    in_out  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.done_i) state_d = S_START;
      end
      S_START: begin
        col_d   = '0;
        row_d   = '0;
        gap_d   = '0;
        state_d = S_FILL;
      end
      S_FILL: begin
        accept = bus.valid_i;
        if (accept) begin
          col_d = col_q + CW'(1);
          if (col_q == COL_PRIME) state_d = S_OUT;
        end
      end
      S_OUT: begin
        accept = bus.valid_i;
        in_out = 1'b1;
        if (accept) begin
          if (col_q == COL_LAST) begin
            col_d   = '0;
            state_d = (row_q == ROW_LAST) ? S_FINISH : S_GAP;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          row_d   = row_q + RW'(1);
          state_d = S_FILL;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_FINISH: begin
        col_d   = '0;
        row_d   = '0;
        gap_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        col_d   = '0;
        row_d   = '0;
        gap_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over every other transition; the frame is dropped silently.
    if (bus.abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      col_d   = '0;
      row_d   = '0;
      gap_d   = '0;
    end

    ready_d = (state_d == S_FILL) || (state_d == S_OUT);
    busy_d  = (state_d != S_IDLE);
    prog_d  = (state_d == S_FINISH);
  end

  // State, counters and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      gap_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      prog_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      gap_q   <= gap_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      prog_q  <= prog_d;
    end
  end

  // Accept-driven strobes follow the current cycle's handshake directly.
  assign bus.count_en      = accept;
  assign bus.done_o        = accept & in_out;
  assign bus.ready_o       = ready_q;
  assign bus.busy_o        = busy_q;
  assign bus.progress_done = prog_q;
  assign bus.col_o         = col_q;
  assign bus.row_o         = row_q;

endmodule

// File: tb/tb_window_buffer_nxn_controller.sv
// Scoreboard bench for the NxN window controller (small frame plus a default-like frame).
module tb_window_buffer_nxn_controller;

  localparam int unsigned KA = 3, WA = 8, HA = 6, GA = 2;
  localparam int unsigned CWA = $clog2(WA), RWA = $clog2(HA), ORA = HA - KA + 1;
  localparam int unsigned KB = 7, WB = 16, HB = 8, GB = 1;
  localparam int unsigned CWB = $clog2(WB), RWB = $clog2(HB), ORB = HB - KB + 1;

  typedef struct {
    int row;
    int col;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t sb_q[$];

  window_buffer_nxn_controller_if #(.CW(CWA), .RW(RWA)) a_if ();
  window_buffer_nxn_controller_if #(.CW(CWB), .RW(RWB)) b_if ();

  window_buffer_nxn_controller #(.K(KA), .IMG_W(WA), .IMG_H(HA), .GAP_CYC(GA)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if.slave)
  );

  window_buffer_nxn_controller #(.K(KB), .IMG_W(WB), .IMG_H(HB), .GAP_CYC(GB)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full frame on DUT A with valid held high, optional stall and stray done_i.
  task automatic run_frame_a(input bit do_stall, input bit poke_done, input string name);
    int   cyc, pulses, accepts, idle_cyc, last_pulse, prog_cyc, stall_left;
    bit   stalled;
    logic v, d;
    exp_t e;
    cyc = 0; pulses = 0; accepts = 0; idle_cyc = 0;
    last_pulse = -1; prog_cyc = -1; stall_left = 0; stalled = 1'b0;
    sb_q.delete();
    for (int r = 0; r < int'(ORA); r++)
      for (int c = int'(KA) - 1; c < int'(WA); c++) begin
        e.row = r; e.col = c;
        sb_q.push_back(e);
      end
    while (prog_cyc < 0 && cyc < 400) begin
      @(negedge clk);
      v = 1'b1;
      d = (cyc == 0) || (poke_done && cyc == 15);
      if (do_stall && !stalled && a_if.ready_o && int'(a_if.row_o) == 0 && int'(a_if.col_o) == 4) begin
        stalled = 1'b1;
        stall_left = 5;
      end
      if (stall_left > 0) begin
        v = 1'b0;
        stall_left--;
      end
      a_if.valid_i = v; a_if.done_i = d; a_if.abort_i = 1'b0;
      #1;
      if (v == 1'b0) begin
        checks++;
        if (int'(a_if.col_o) !== 4 || a_if.done_o !== 1'b0 || a_if.count_en !== 1'b0) begin
          failures++;
          $display("FAIL %s stall: col=%0d done_o=%b count_en=%b, expected col=4 done_o=0 count_en=0",
                   name, a_if.col_o, a_if.done_o, a_if.count_en);
        end
      end
      if (a_if.count_en === 1'b1) accepts++;
      if (a_if.busy_o === 1'b1 && a_if.ready_o === 1'b0 && a_if.progress_done === 1'b0) idle_cyc++;
      if (a_if.done_o === 1'b1) begin
        pulses++;
        last_pulse = cyc;
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL %s pulse: unexpected at row=%0d col=%0d, expected none", name, a_if.row_o, a_if.col_o);
        end else begin
          e = sb_q.pop_front();
          if (int'(a_if.row_o) !== e.row || int'(a_if.col_o) !== e.col) begin
            failures++;
            $display("FAIL %s pulse: got row=%0d col=%0d, expected row=%0d col=%0d",
                     name, a_if.row_o, a_if.col_o, e.row, e.col);
          end
        end
      end
      if (a_if.progress_done === 1'b1) prog_cyc = cyc;
      cyc++;
    end
    a_if.done_i = 1'b0;
    checks++;
    if (prog_cyc < 0) begin
      failures++;
      $display("FAIL %s timeout: no progress_done within %0d cycles, expected one", name, cyc);
    end
    checks++;
    if (sb_q.size() != 0 || pulses != int'(ORA * (WA - KA + 1))) begin
      failures++;
      $display("FAIL %s pulse_count: got %0d (left %0d), expected %0d", name, pulses, sb_q.size(), ORA * (WA - KA + 1));
    end
    checks++;
    if (accepts != int'(ORA * WA)) begin
      failures++;
      $display("FAIL %s accepts: got %0d, expected %0d", name, accepts, ORA * WA);
    end
    checks++;
    if (idle_cyc != int'(1 + (ORA - 1) * GA)) begin
      failures++;
      $display("FAIL %s start_gap_cycles: got %0d, expected %0d", name, idle_cyc, 1 + (ORA - 1) * GA);
    end
    checks++;
    if (prog_cyc != last_pulse + 1) begin
      failures++;
      $display("FAIL %s progress_timing: got cycle %0d, expected %0d", name, prog_cyc, last_pulse + 1);
    end
    @(negedge clk);
    a_if.valid_i = 1'b0;
    #1;
    checks++;
    if (a_if.busy_o !== 1'b0 || a_if.progress_done !== 1'b0) begin
      failures++;
      $display("FAIL %s back_to_idle: busy=%b progress=%b, expected 0 0", name, a_if.busy_o, a_if.progress_done);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({a_if.busy_o, a_if.ready_o, a_if.count_en, a_if.done_o, a_if.progress_done} !== 5'b0 ||
        a_if.col_o !== '0 || a_if.row_o !== '0 ||
        {b_if.busy_o, b_if.ready_o, b_if.count_en, b_if.done_o, b_if.progress_done} !== 5'b0) begin
      failures++;
      $display("FAIL reset_state: a busy=%b ready=%b col=%0d row=%0d, b busy=%b, expected all 0",
               a_if.busy_o, a_if.ready_o, a_if.col_o, a_if.row_o, b_if.busy_o);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_if.valid_i = 1'b1;
      #1;
      checks++;
      if (a_if.busy_o !== 1'b0 || a_if.count_en !== 1'b0) begin
        failures++;
        $display("FAIL idle_after_reset: busy=%b count_en=%b, expected 0 0", a_if.busy_o, a_if.count_en);
      end
    end
    a_if.valid_i = 1'b0;
  endtask

  task automatic test_nominal();
    run_frame_a(1'b0, 1'b0, "nominal");
  endtask

  task automatic test_back_to_back();
    run_frame_a(1'b0, 1'b0, "b2b_first");
    run_frame_a(1'b0, 1'b0, "b2b_second");
  endtask

  task automatic test_stall();
    run_frame_a(1'b1, 1'b0, "stall");
  endtask

  task automatic test_abort();
    int  cyc;
    bit  hit;
    cyc = 0; hit = 1'b0;
    while (!hit && cyc < 400) begin
      @(negedge clk);
      a_if.done_i  = (cyc == 0);
      a_if.valid_i = 1'b1;
      if (a_if.ready_o && int'(a_if.row_o) == 2 && int'(a_if.col_o) == 5) begin
        hit = 1'b1;
        a_if.abort_i = 1'b1;
      end
      #1;
      cyc++;
    end
    a_if.done_i = 1'b0;
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL abort_reach: row 2 col 5 not reached in %0d cycles, expected reached", cyc);
    end
    checks++;
    if (a_if.count_en !== 1'b1 || a_if.done_o !== 1'b1) begin
      failures++;
      $display("FAIL abort_same_cycle: count_en=%b done_o=%b, expected 1 1", a_if.count_en, a_if.done_o);
    end
    @(negedge clk);
    a_if.abort_i = 1'b0;
    a_if.valid_i = 1'b0;
    #1;
    checks++;
    if (a_if.busy_o !== 1'b0 || a_if.col_o !== '0 || a_if.row_o !== '0 || a_if.ready_o !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle: busy=%b col=%0d row=%0d ready=%b, expected 0 0 0 0",
               a_if.busy_o, a_if.col_o, a_if.row_o, a_if.ready_o);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (a_if.progress_done !== 1'b0 || a_if.busy_o !== 1'b0) begin
        failures++;
        $display("FAIL abort_no_progress: progress=%b busy=%b, expected 0 0", a_if.progress_done, a_if.busy_o);
      end
    end
    run_frame_a(1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_async_reset();
    int cyc;
    bit hit;
    cyc = 0; hit = 1'b0;
    while (!hit && cyc < 400) begin
      @(negedge clk);
      a_if.done_i  = (cyc == 0);
      a_if.valid_i = 1'b1;
      #1;
      if (a_if.busy_o === 1'b1 && a_if.ready_o === 1'b0 && a_if.progress_done === 1'b0 && int'(a_if.row_o) == 1)
        hit = 1'b1;
      cyc++;
    end
    a_if.done_i = 1'b0;
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL areset_reach: gap after row 1 not reached in %0d cycles, expected reached", cyc);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_if.busy_o, a_if.ready_o, a_if.count_en, a_if.done_o, a_if.progress_done} !== 5'b0 ||
        a_if.col_o !== '0 || a_if.row_o !== '0) begin
      failures++;
      $display("FAIL areset_outputs: busy=%b ready=%b count_en=%b row=%0d col=%0d, expected all 0",
               a_if.busy_o, a_if.ready_o, a_if.count_en, a_if.row_o, a_if.col_o);
    end
    @(negedge clk);
    @(negedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (a_if.busy_o !== 1'b0 || a_if.progress_done !== 1'b0) begin
        failures++;
        $display("FAIL areset_discard: busy=%b progress=%b, expected 0 0", a_if.busy_o, a_if.progress_done);
      end
    end
    run_frame_a(1'b0, 1'b1, "post_reset");
  endtask

  task automatic test_defaults();
    int   cyc, pulses, idle_cyc, prog_cnt;
    exp_t e;
    cyc = 0; pulses = 0; idle_cyc = 0; prog_cnt = 0;
    sb_q.delete();
    for (int r = 0; r < int'(ORB); r++)
      for (int c = int'(KB) - 1; c < int'(WB); c++) begin
        e.row = r; e.col = c;
        sb_q.push_back(e);
      end
    while (prog_cnt == 0 && cyc < 400) begin
      @(negedge clk);
      b_if.done_i  = (cyc == 0);
      b_if.valid_i = 1'b1;
      b_if.abort_i = 1'b0;
      #1;
      if (b_if.busy_o === 1'b1 && b_if.ready_o === 1'b0 && b_if.progress_done === 1'b0) idle_cyc++;
      if (b_if.progress_done === 1'b1) prog_cnt++;
      if (b_if.done_o === 1'b1) begin
        pulses++;
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL defaults pulse: unexpected at row=%0d col=%0d, expected none", b_if.row_o, b_if.col_o);
        end else begin
          e = sb_q.pop_front();
          if (int'(b_if.row_o) !== e.row || int'(b_if.col_o) !== e.col) begin
            failures++;
            $display("FAIL defaults pulse: got row=%0d col=%0d, expected row=%0d col=%0d",
                     b_if.row_o, b_if.col_o, e.row, e.col);
          end
        end
      end
      cyc++;
    end
    b_if.done_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b_if.valid_i = 1'b0;
      #1;
      if (b_if.progress_done === 1'b1) prog_cnt++;
    end
    checks++;
    if (pulses != 20 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL defaults pulse_count: got %0d, expected 20", pulses);
    end
    checks++;
    if (idle_cyc != 2) begin
      failures++;
      $display("FAIL defaults start_gap_cycles: got %0d, expected 2", idle_cyc);
    end
    checks++;
    if (prog_cnt != 1 || b_if.busy_o !== 1'b0) begin
      failures++;
      $display("FAIL defaults finish: progress pulses=%0d busy=%b, expected 1 0", prog_cnt, b_if.busy_o);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    a_if.done_i = 1'b0; a_if.valid_i = 1'b0; a_if.abort_i = 1'b0;
    b_if.done_i = 1'b0; b_if.valid_i = 1'b0; b_if.abort_i = 1'b0;
    test_reset();
    test_nominal();
    test_back_to_back();
    test_stall();
    test_abort();
    test_async_reset();
    test_defaults();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
